// File: rtl/mem_responder_if.sv
// mem_responder_if: RAM request bus between fetch/load-store initiators and mem_responder.
//   ram_read/ram_write   level command requests from the initiator
//   ram_addr/ram_wdata   word address and write halfword, sampled on accept
//   ram_data             {hi,lo} read word, held until the next read completes
//   ram_cack             one-cycle accept pulse
//   ram_busy             command in progress
//   ram_data_ready       one-cycle read-valid / write-done pulse
interface mem_responder_if;
   logic        ram_read;
   logic        ram_write;
   logic [15:0] ram_addr;
   logic [15:0] ram_wdata;
   logic [31:0] ram_data;
   logic        ram_cack;
   logic        ram_busy;
   logic        ram_data_ready;
   modport master (
      output ram_read, ram_write, ram_addr, ram_wdata,
      input  ram_data, ram_cack, ram_busy, ram_data_ready
   );
   modport slave (
      input  ram_read, ram_write, ram_addr, ram_wdata,
      output ram_data, ram_cack, ram_busy, ram_data_ready
   );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: serves one RAM read/write command at a time on a 16-bit asynchronous SRAM.
//   clk, rst      posedge clock, asynchronous active-high reset
//   bus           slave side of the RAM request bus
//   sram_addr     17-bit halfword address
//   sram_dq_in    SRAM read data
//   sram_dq_out   SRAM write data
//   sram_oe       output enable, active-high
//   sram_we       write enable, active-high
// A read is two halfword accesses (lo at even, hi at odd halfword); a write is one
// access to the even halfword. Each access is held for WAIT_STATES+1 cycles.
module mem_responder #(
   parameter int WAIT_STATES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   mem_responder_if.slave        bus,
   output logic [16:0]           sram_addr,
   input  logic [15:0]           sram_dq_in,
   output logic [15:0]           sram_dq_out,
   output logic                  sram_oe,
   output logic                  sram_we
);
   localparam logic [3:0] WS = 4'(WAIT_STATES);
   typedef enum logic [1:0] {IDLE, RD_LO, RD_HI, WR} state_t;
   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [15:0] lo_q, lo_d;
   logic [31:0] data_q, data_d;
   logic        cack_q, cack_d;
   logic        busy_q, busy_d;
   logic        rdy_q, rdy_d;
   logic [16:0] addr_q, addr_d;
   logic [15:0] dq_out_q, dq_out_d;
   logic        oe_q, oe_d;
   logic        we_q, we_d;
   logic        done;
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 4'd1;
      lo_d     = lo_q;
      data_d   = data_q;
      cack_d   = 1'b0;
      busy_d   = busy_q;
      rdy_d    = 1'b0;
      addr_d   = addr_q;
      dq_out_d = dq_out_q;
      oe_d     = oe_q;
      we_d     = we_q;
      done     = cnt_q == WS;
      case (state_q)
         IDLE: begin
            cnt_d = cnt_q;
            // read has priority; a simultaneous write is left unacked for retry
            if (bus.ram_read || bus.ram_write) begin
               state_d  = bus.ram_read ? RD_LO : WR;
               cnt_d    = '0;
               cack_d   = 1'b1;
               busy_d   = 1'b1;
               addr_d   = {bus.ram_addr, 1'b0};
               dq_out_d = bus.ram_read ? dq_out_q : bus.ram_wdata;
               oe_d     = bus.ram_read;
               we_d     = !bus.ram_read;
            end
         end
         RD_LO: if (done) begin
            lo_d    = sram_dq_in;
            state_d = RD_HI;
            cnt_d   = '0;
            addr_d  = {addr_q[16:1], 1'b1};
         end
         RD_HI, WR: if (done) begin
            data_d  = state_q == RD_HI ? {sram_dq_in, lo_q} : data_q;
            rdy_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
            oe_d    = 1'b0;
            we_d    = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         lo_q     <= '0;
         data_q   <= '0;
         cack_q   <= 1'b0;
         busy_q   <= 1'b0;
         rdy_q    <= 1'b0;
         addr_q   <= '0;
         dq_out_q <= '0;
         oe_q     <= 1'b0;
         we_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         lo_q     <= lo_d;
         data_q   <= data_d;
         cack_q   <= cack_d;
         busy_q   <= busy_d;
         rdy_q    <= rdy_d;
         addr_q   <= addr_d;
         dq_out_q <= dq_out_d;
         oe_q     <= oe_d;
         we_q     <= we_d;
      end
   end
   assign bus.ram_data       = data_q;
   assign bus.ram_cack       = cack_q;
   assign bus.ram_busy       = busy_q;
   assign bus.ram_data_ready = rdy_q;
   assign sram_addr          = addr_q;
   assign sram_dq_out        = dq_out_q;
   assign sram_oe            = oe_q;
   assign sram_we            = we_q;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed and random checks of mem_responder at WAIT_STATES=1 and 0.
module tb_mem_responder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   mem_responder_if bus1();
   mem_responder_if bus0();
   logic [16:0] sa1, sa0;
   logic [15:0] din1 = '0, din0 = '0, dout1, dout0;
   logic        oe1, we1, oe0, we0;
   mem_responder #(.WAIT_STATES(1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .sram_addr(sa1), .sram_dq_in(din1),
      .sram_dq_out(dout1), .sram_oe(oe1), .sram_we(we1)
   );
   mem_responder #(.WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0), .sram_addr(sa0), .sram_dq_in(din0),
      .sram_dq_out(dout0), .sram_oe(oe0), .sram_we(we0)
   );
   function automatic logic [15:0] init_val(input logic [16:0] h);
      return h == 17'h20 ? 16'h1234 : h == 17'h21 ? 16'hABCD : 16'(h * 17'h00B3) ^ 16'hC3A5;
   endfunction
   logic [15:0] sram [int];
   logic [15:0] refm [int];
   always @(negedge clk) begin
      if (we1) sram[int'(sa1)] = dout1;
      if (we0) sram[int'(sa0)] = dout0;
      din1 = sram.exists(int'(sa1)) ? sram[int'(sa1)] : init_val(sa1);
      din0 = sram.exists(int'(sa0)) ? sram[int'(sa0)] : init_val(sa0);
   end
   function automatic logic [15:0] ref_half(input logic [16:0] h);
      return refm.exists(int'(h)) ? refm[int'(h)] : init_val(h);
   endfunction
   function automatic logic [31:0] ref_word(input logic [15:0] a);
      return {ref_half({a, 1'b1}), ref_half({a, 1'b0})};
   endfunction
   bit sel = 1'b1;
   bit clash = 1'b0;
   always @(negedge clk) if ((oe1 && we1) || (oe0 && we0)) clash = 1'b1;
   logic        o_cack, o_busy, o_rdy, o_oe, o_we;
   logic [31:0] o_data;
   logic [16:0] o_addr;
   logic [15:0] o_dout;
   assign o_cack = sel ? bus1.ram_cack : bus0.ram_cack;
   assign o_busy = sel ? bus1.ram_busy : bus0.ram_busy;
   assign o_rdy  = sel ? bus1.ram_data_ready : bus0.ram_data_ready;
   assign o_data = sel ? bus1.ram_data : bus0.ram_data;
   assign o_addr = sel ? sa1 : sa0;
   assign o_dout = sel ? dout1 : dout0;
   assign o_oe   = sel ? oe1 : oe0;
   assign o_we   = sel ? we1 : we0;
   int checks = 0;
   int errors = 0;
   logic [31:0] last [2];
   logic [16:0] first_addr, last_addr;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask
   task automatic drive(input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] d);
      bus1.ram_read  = sel & rd;
      bus1.ram_write = sel & wr;
      bus1.ram_addr  = a;
      bus1.ram_wdata = d;
      bus0.ram_read  = !sel & rd;
      bus0.ram_write = !sel & wr;
      bus0.ram_addr  = a;
      bus0.ram_wdata = d;
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_cack(input string tag);
      int n = 0;
      do begin step(); n++; end while (!o_cack && n < 40);
      chk({tag, "_cack"}, o_cack, 1);
      chk({tag, "_busy_at_cack"}, o_busy, 1);
   endtask
   task automatic txn(input bit rd, input logic [15:0] a, input logic [15:0] d, input string tag);
      int n, we_n, ws;
      logic [31:0] exp;
      ws  = sel ? 1 : 0;
      exp = rd ? ref_word(a) : last[sel];
      drive(rd, !rd, a, d);
      wait_cack(tag);
      drive(0, 0, a, d);
      first_addr = o_addr;
      last_addr  = o_addr;
      we_n = o_we ? 1 : 0;
      n = 0;
      do begin
         step();
         n++;
         we_n += o_we ? 1 : 0;
         if (o_oe) last_addr = o_addr;
      end while (!o_rdy && n < 40);
      chk({tag, "_ready"}, o_rdy, 1);
      chk({tag, "_latency"}, n, rd ? 2 * ws + 2 : ws + 1);
      chk({tag, "_busy_in_ready"}, o_busy, 0);
      chk({tag, "_data"}, o_data, exp);
      chk({tag, "_we_cycles"}, we_n, rd ? 0 : ws + 1);
      if (rd) last[sel] = exp;
      else refm[int'({a, 1'b0})] = d;
      step();
      chk({tag, "_ready_pulse"}, o_rdy, 0);
   endtask
   initial begin
      int n, extra, we_n;
      logic [15:0] a, b;
      logic [31:0] ea, eb;
      logic [15:0] wq [$];
      last[0] = '0;
      last[1] = '0;
      drive(0, 0, 0, 0);
      step();
      step();
      chk("rst_data", o_data, 0);
      chk("rst_cack", o_cack, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_ready", o_rdy, 0);
      chk("rst_sram_addr", o_addr, 0);
      chk("rst_oe_we", {o_oe, o_we}, 0);
      rst = 1'b0;
      step();
      txn(1, 16'h0010, 0, "single_read");
      chk("single_read_word", last[1], 32'hABCD1234);
      txn(0, 16'h0003, 16'h5A5A, "write3");
      chk("write3_sram_addr", first_addr, 17'h00006);
      txn(1, 16'h0003, 0, "read3");
      chk("read3_lo", last[1] & 32'hFFFF, 32'h5A5A);
      a = 16'h0040;
      ea = ref_word(a);
      drive(1, 1, a, 16'h7777);
      wait_cack("simul");
      chk("simul_oe", {o_oe, o_we}, 2'b10);
      drive(0, 1, a, 16'h7777);
      we_n = 0;
      n = 0;
      do begin step(); n++; we_n += o_we ? 1 : 0; end while (!o_rdy && n < 40);
      chk("simul_read_ready", o_rdy, 1);
      chk("simul_read_data", o_data, ea);
      chk("simul_no_we", we_n, 0);
      last[1] = ea;
      step();
      chk("simul_retry_cack", o_cack, 1);
      chk("simul_retry_we", o_we, 1);
      drive(0, 0, a, 0);
      n = 0;
      do begin step(); n++; end while (!o_rdy && n < 40);
      chk("simul_retry_latency", n, 2);
      refm[int'({a, 1'b0})] = 16'h7777;
      step();
      txn(1, a, 0, "simul_verify");
      a = 16'h0055;
      b = 16'h0056;
      ea = ref_word(a);
      eb = ref_word(b);
      drive(1, 0, a, 0);
      wait_cack("busy_first");
      drive(1, 0, b, 0);
      extra = 0;
      n = 0;
      do begin step(); n++; extra += o_cack ? 1 : 0; end while (!o_rdy && n < 40);
      chk("busy_no_cack", extra, 0);
      chk("busy_first_latency", n, 4);
      chk("busy_first_data", o_data, ea);
      step();
      chk("busy_second_cack", o_cack, 1);
      chk("busy_data_hold", o_data, ea);
      drive(0, 0, b, 0);
      n = 0;
      do begin step(); n++; end while (!o_rdy && n < 40);
      chk("busy_second_latency", n, 4);
      chk("busy_second_data", o_data, eb);
      last[1] = eb;
      step();
      drive(0, 1, 16'h0100, 16'hBEEF);
      wait_cack("abort_wr");
      drive(0, 0, 0, 0);
      chk("abort_we_before", o_we, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_we_async", o_we, 0);
      chk("abort_busy", o_busy, 0);
      chk("abort_cack_ready", {o_cack, o_rdy}, 0);
      chk("abort_sram", {o_addr, o_dout, o_oe}, 0);
      chk("abort_data", o_data, 0);
      step();
      rst = 1'b0;
      last[0] = '0;
      last[1] = '0;
      extra = 0;
      for (int i = 0; i < 5; i++) begin step(); extra += o_rdy ? 1 : 0; end
      chk("abort_no_ready", extra, 0);
      txn(1, 16'hFFFF, 0, "top_read");
      chk("top_lo_addr", first_addr, 17'h1FFFE);
      chk("top_hi_addr", last_addr, 17'h1FFFF);
      sel = 1'b0;
      step();
      txn(1, 16'h0010, 0, "zw_read");
      txn(0, 16'h0200, 16'hC0DE, "zw_write");
      txn(1, 16'h0200, 0, "zw_readback");
      for (int s = 0; s < 2; s++) begin
         sel = s == 0;
         for (int i = 0; i < 30; i++) begin
            bit rd;
            int r;
            rd = $urandom_range(0, 1) == 1;
            r = $urandom_range(0, 7);
            a = r == 0 ? 16'h0000 : r == 1 ? 16'hFFFF : 16'($urandom);
            if (rd && wq.size() > 0 && $urandom_range(0, 1) == 1) a = wq[$urandom_range(0, wq.size() - 1)];
            if (a == 16'h0100) a = 16'h0101;
            if (!rd) wq.push_back(a);
            txn(rd, a, 16'($urandom), rd ? "rnd_read" : "rnd_write");
         end
      end
      chk("no_oe_we_overlap", clash, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_responder.md
# mem_responder

Target side of the core's RAM request protocol, serving fetch and load/store initiators. It accepts one read or write command at a time and runs it against an external 16-bit asynchronous SRAM. Each read is two SRAM halfword accesses assembled into a 32-bit word; each write is one halfword access. It reports progress with `ram_busy`, `ram_cack` and `ram_data_ready`. All logic runs on posedge `clk`; initiators sample on negedge.

## Interface
- `WAIT_STATES`, default 1: extra cycles each SRAM access is held before sampling or ending the write (range 0–15).
- `clk`  in  1  system clock, posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ram_read`  in  1  read command request (level).
- `ram_write`  in  1  write command request (level).
- `ram_addr`  in  16  word address.
- `ram_wdata`  in  16  write data.
- `ram_data`  out  32  read data, `{hi,lo}`; holds until the next read completes.
- `ram_cack`  out  1  command accepted, 1-cycle pulse.
- `ram_busy`  out  1  command in progress.
- `ram_data_ready`  out  1  read data valid or write done, 1-cycle pulse.
- `sram_addr`  out  17  halfword address.
- `sram_dq_in`  in  16  SRAM read data.
- `sram_dq_out`  out  16  SRAM write data.
- `sram_oe`  out  1  output enable, active-high.
- `sram_we`  out  1  write enable, active-high.

## Operation
- States: IDLE, RD_LO, RD_HI, WR. Phase counter `cnt` is 4 bits.
- **IDLE accept.** At a posedge with `ram_read` high, latch `ram_addr`, go to RD_LO, `cnt<=0`, `ram_cack<=1`, `ram_busy<=1`.
- **Write accept.** Otherwise, with `ram_write` high, latch `ram_addr` and `ram_wdata` and go to WR, with the same `cnt`, `ram_cack` and `ram_busy` updates.
- **Simultaneous read and write.** Read wins. The write is not acked; the initiator retries.
- **Requests outside IDLE.** Ignored, no `ram_cack`. The initiator retry-until-cack rule covers this.
- **RD_LO.**
  - Drive `sram_addr={addr,1'b0}`, `sram_oe=1`.
  - At the edge where `cnt==WAIT_STATES`: `lo<=sram_dq_in`, go to RD_HI, `cnt<=0`.
  - Otherwise `cnt<=cnt+1`.
- **RD_HI.**
  - Drive `sram_addr={addr,1'b1}`, `sram_oe=1`.
  - At the edge where `cnt==WAIT_STATES`: `ram_data<={sram_dq_in,lo}`, `ram_data_ready<=1`, `ram_busy<=0`, go to IDLE.
- **WR.**
  - Drive `sram_addr={addr,1'b0}`, `sram_dq_out=wdata`, `sram_we=1`.
  - At the edge where `cnt==WAIT_STATES`: `ram_data_ready<=1`, `ram_busy<=0`, go to IDLE.
  - `ram_data` is unchanged.
- **Strobes.** `sram_oe` and `sram_we` are registered with the state and are never high together. Both are 0 in IDLE.
- **Address width.** `sram_addr` is the 16-bit word address shifted left 1 bit into 17 bits. The top word `0xFFFF` maps to halfwords 0x1FFFE and 0x1FFFF; there is no wrap.
- **Reset.**
  - `ram_data=0`, `ram_cack=0`, `ram_busy=0`, `ram_data_ready=0`, `sram_addr=0`, `sram_dq_out=0`, `sram_oe=0`, `sram_we=0`, state IDLE, `cnt=0`.
  - Reset mid-command aborts immediately: `sram_we` drops asynchronously, and no `ram_data_ready` is issued.

## Timing
- **Cack.** High exactly one cycle, the cycle after the accept edge E0.
- **Read latency.** `ram_data_ready` rises at edge E(2·WAIT_STATES+2). WAIT_STATES=1 gives 4 cycles; WAIT_STATES=0 gives 2 cycles.
- **Write latency.** `ram_data_ready` rises at edge E(WAIT_STATES+1).
- **Busy.** High from E0 until the completion edge. It is low during the `ram_data_ready` cycle.
- **Back-to-back.** A new command can be accepted at the edge ending the `ram_data_ready` cycle. The minimum read-to-read period is 2·WAIT_STATES+3 cycles.
- **Data hold.** `ram_data` is stable from `ram_data_ready` until the next read's completion edge, so a negedge sampler sees it valid.

## Test plan
- **Single read.** WAIT_STATES=1; SRAM[0x0020]=0x1234, SRAM[0x0021]=0xABCD; read `ram_addr=0x0010` -> `ram_cack` 1 cycle, `ram_data_ready` 4 cycles after accept, `ram_data=0xABCD1234`, `ram_busy` low that cycle.
- **Write then read.** Write 0x5A5A to addr 0x0003 -> `sram_we` high 2 cycles at `sram_addr=0x00006`, ready at +2. Then read 0x0003 -> low half 0x5A5A.
- **Simultaneous request.** `ram_read`=`ram_write`=1 -> read executes and `sram_we` is never asserted. A write held through completion is then acked on the next IDLE edge.
- **Request while busy.** A second read raised during RD_LO gets no `ram_cack` until the first completes. Its `ram_cack` appears on the first IDLE edge after `ram_data_ready`.
- **Reset mid-command.** `rst` pulsed during WR -> `sram_we`=0 immediately, no `ram_data_ready`, all outputs 0. A following read to 0xFFFF uses `sram_addr` 0x1FFFE then 0x1FFFF.
- **Zero wait states.** WAIT_STATES=0 -> read ready 2 cycles after accept, write ready 1 cycle after accept.
